// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) self-test sequencer.
package hamming_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int N_VEC  = 128;
  localparam int ERR_W  = 3;
  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  // Error index 0 leaves the codeword clean; index k flips bit k-1, and in
  // double mode also flips bit (k mod 7) so the pair is always distinct.
  function automatic logic [CW_W-1:0] make_mask(input logic [ERR_W-1:0] idx,
                                                input logic dbl);
    logic [CW_W-1:0] m;
    m = '0;
    for (int k = 1; k <= 7; k++) begin
      if (idx == ERR_W'(k)) begin
        m[k-1] = 1'b1;
        if (dbl) m[k % 7] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_test_seq_codec.sv
// Hamming(7,4) encode, error injection and single-error-correcting decode.
// Codeword position p (1..7) lives in bit p-1: p1 p2 d0 p3 d1 d2 d3.
module hamming74_codec
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] d_in,
  input  logic [CW_W-1:0]   error,
  output logic [DATA_W-1:0] d_out
);

  logic [CW_W-1:0]  cw;
  logic [CW_W-1:0]  rx;
  logic [CW_W-1:0]  fixed;
  logic [ERR_W-1:0] syn;

  // Encode, inject, then flip the bit the syndrome points at.
  always_comb begin
    cw[0] = d_in[0] ^ d_in[1] ^ d_in[3];
    cw[1] = d_in[0] ^ d_in[2] ^ d_in[3];
    cw[2] = d_in[0];
    cw[3] = d_in[1] ^ d_in[2] ^ d_in[3];
    cw[4] = d_in[1];
    cw[5] = d_in[2];
    cw[6] = d_in[3];
    rx    = cw ^ error;
    syn[0] = rx[0] ^ rx[2] ^ rx[4] ^ rx[6];
    syn[1] = rx[1] ^ rx[2] ^ rx[5] ^ rx[6];
    syn[2] = rx[3] ^ rx[4] ^ rx[5] ^ rx[6];
    fixed = rx;
    for (int k = 1; k <= 7; k++) begin
      if (syn == ERR_W'(k)) fixed[k-1] = ~rx[k-1];
    end
    d_out = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

endmodule

// File: rtl/hamming_test_seq.sv
// Sweeps all 16 nibbles x 8 error patterns through the codec and tallies
// how many decode back to the source nibble.
//
// state | meaning
// IDLE  | waiting for start (also after abort)
// APPLY | codec driven with cur_data/mask, dwell counting
// CHECK | one cycle: tally result, advance to next vector
// DONE  | sweep finished, results held until next start
module hamming_test_seq
  import hamming_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              dbl_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [DATA_W-1:0] cur_data,
  output logic [ERR_W-1:0]  cur_err
);

  localparam logic [3:0]        DWELL_LAST = 4'(DWELL - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST   = '1;
  localparam logic [DATA_W-1:0] DATA_LAST  = '1;

  state_t            state;
  logic [3:0]        dwell_cnt;
  logic [1:0]        rst_sync;
  logic [CW_W-1:0]   err_mask;
  logic [DATA_W-1:0] d_out;
  logic              match;

  assign err_mask = make_mask(cur_err, dbl_en);
  assign match    = (d_out == cur_data);

  hamming74_codec u_codec (
    .d_in  (cur_data),
    .error (err_mask),
    .d_out (d_out)
  );

  // Two-stage release synchroniser; start is ignored until it has filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // Sequencer FSM with registered status and tally outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dwell_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      cur_data  <= '0;
      cur_err   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && rst_sync[1]) begin
            state     <= ST_APPLY;
            dwell_cnt <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            cur_data  <= '0;
            cur_err   <= '0;
          end
        end
        ST_APPLY: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            state     <= ST_CHECK;
          end else begin
            dwell_cnt <= dwell_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            if (match) pass_cnt <= pass_cnt + 8'd1;
            else       fail_cnt <= fail_cnt + 8'd1;
            if (cur_err == ERR_LAST) begin
              if (cur_data == DATA_LAST) begin
                // Last vector: hold 15/7 on the outputs.
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                cur_err  <= '0;
                cur_data <= cur_data + 4'd1;
                state    <= ST_APPLY;
              end
            end else begin
              cur_err <= cur_err + 3'd1;
              state   <= ST_APPLY;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
